// File: rtl/pram_boot_loader.sv
// Boot loader: streams header, 12-bit words and a checksum from a host byte
// link into the program RAM, holding the core in reset until the load is good.
// Ports: clk, rst (async, active-high); byte_data/byte_valid/byte_ready host
// stream; reboot restart request; pram_wr_addr/pram_din/pram_we RAM write
// port; core_hold, boot_done, boot_err status.
module pram_boot_loader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              reboot,
  output logic [ADDR_W-1:0] pram_wr_addr,
  output logic [DATA_W-1:0] pram_din,
  output logic              pram_we,
  output logic              core_hold,
  output logic              boot_done,
  output logic              boot_err
);

  typedef enum logic [2:0] {
    S_HDR_LO,
    S_HDR_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] sum_q, sum_d;
  logic we_q, we_d;
  logic hold_q, hold_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic accepting;
  logic xfer;

  always_comb begin
    accepting = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
                (state_q == S_DATA_LO) || (state_q == S_DATA_HI) ||
                (state_q == S_CSUM);
    // A byte offered alongside reboot must not be consumed.
    byte_ready = accepting & ~reboot;
    xfer = byte_valid & byte_ready;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wa_d    = wa_q;
    din_d   = din_q;
    lo_d    = lo_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    // The checksum byte itself is excluded from the running sum.
    if (xfer && state_q != S_CSUM) sum_d = sum_q + byte_data;
    unique case (state_q)
      S_HDR_LO: if (xfer) begin
        len_d   = {len_q[ADDR_W-1:8], byte_data};
        state_d = S_HDR_HI;
      end
      S_HDR_HI: if (xfer) begin
        len_d   = {byte_data[ADDR_W-9:0], len_q[7:0]};
        addr_d  = '0;
        state_d = S_DATA_LO;
      end
      S_DATA_LO: if (xfer) begin
        lo_d    = byte_data;
        state_d = S_DATA_HI;
      end
      S_DATA_HI: if (xfer) begin
        din_d   = {byte_data[DATA_W-9:0], lo_q};
        wa_d    = addr_q;
        we_d    = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (addr_q == len_q) begin
          state_d = S_CSUM;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_DATA_LO;
        end
      end
      S_CSUM: if (xfer) begin
        if (byte_data == sum_q) begin
          state_d = S_DONE;
          hold_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_DONE: ;
      S_ERR: ;
      default: state_d = S_HDR_LO;
    endcase
    if (reboot) begin
      state_d = S_HDR_LO;
      len_d   = '0;
      addr_d  = '0;
      sum_d   = '0;
      we_d    = 1'b0;
      hold_d  = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HDR_LO;
      len_q   <= '0;
      addr_q  <= '0;
      wa_q    <= '0;
      din_q   <= '0;
      lo_q    <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wa_q    <= wa_d;
      din_q   <= din_d;
      lo_q    <= lo_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pram_wr_addr = wa_q;
  assign pram_din     = din_q;
  assign pram_we      = we_q;
  assign core_hold    = hold_q;
  assign boot_done    = done_q;
  assign boot_err     = err_q;

endmodule

// File: tb/tb_pram_boot_loader.sv
// Scoreboard bench for pram_boot_loader: a stream builder queues the
// expected RAM writes, a negedge monitor pops and compares each pram_we.
module tb_pram_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        reboot = 1'b0;
  logic [10:0] pram_wr_addr;
  logic [11:0] pram_din;
  logic        pram_we;
  logic        core_hold;
  logic        boot_done;
  logic        boot_err;

  pram_boot_loader dut (
    .clk(clk),
    .rst(rst),
    .byte_data(byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .reboot(reboot),
    .pram_wr_addr(pram_wr_addr),
    .pram_din(pram_din),
    .pram_we(pram_we),
    .core_hold(core_hold),
    .boot_done(boot_done),
    .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int d;
  } wr_t;

  wr_t exp_q[$];
  logic [7:0] bq[$];
  int lo_a[2048];
  int hi_a[2048];
  int checks = 0;
  int failures = 0;
  int gapmax = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && pram_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected got=%0h@%0h expected=none",
                 pram_din, pram_wr_addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (pram_wr_addr !== 11'(e.a) || pram_din !== 12'(e.d)) begin
          failures++;
          $display("FAIL wr got=%0h@%0h expected=%0h@%0h",
                   pram_din, pram_wr_addr, e.d, e.a);
        end
      end
    end
  end

  // Reference: build the byte stream for n words and queue expected writes.
  task automatic build(input int n, input int junk, input bit bad);
    int len;
    int sum;
    len = n - 1;
    bq.delete();
    bq.push_back(8'(len % 256));
    bq.push_back(8'(len / 256 + junk * 8));
    sum = len % 256 + len / 256 + junk * 8;
    for (int i = 0; i < n; i++) begin
      bq.push_back(8'(lo_a[i]));
      bq.push_back(8'(hi_a[i]));
      sum += lo_a[i] + hi_a[i];
      exp_q.push_back('{i, (hi_a[i] % 16) * 256 + lo_a[i]});
    end
    bq.push_back(8'((sum + (bad ? 1 : 0)) % 256));
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    repeat ($urandom_range(0, gapmax)) @(negedge clk);
    byte_data = b;
    byte_valid = 1'b1;
    #1;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!byte_ready) begin
      chk("send_timeout", 0, 1);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_all();
    for (int i = 0; i < bq.size(); i++) send(bq[i]);
  endtask

  task automatic status(input bit good);
    repeat (2) @(negedge clk);
    chk("boot_done", int'(boot_done), int'(good));
    chk("boot_err", int'(boot_err), int'(!good));
    chk("core_hold", int'(core_hold), int'(!good));
    chk("ready_idle", int'(byte_ready), 0);
    chk("writes_left", exp_q.size(), 0);
  endtask

  task automatic do_reboot();
    reboot = 1'b1;
    #1;
    chk("ready_gated", int'(byte_ready), 0);
    @(negedge clk);
    reboot = 1'b0;
    #1;
    chk("rb_hold", int'(core_hold), 1);
    chk("rb_done", int'(boot_done), 0);
    chk("rb_err", int'(boot_err), 0);
    chk("rb_ready", int'(byte_ready), 1);
    chk("rb_we", int'(pram_we), 0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ready"}, int'(byte_ready), 1);
    chk({nm, "_we"}, int'(pram_we), 0);
    chk({nm, "_addr"}, int'(pram_wr_addr), 0);
    chk({nm, "_din"}, int'(pram_din), 0);
    chk({nm, "_hold"}, int'(core_hold), 1);
    chk({nm, "_done"}, int'(boot_done), 0);
    chk({nm, "_err"}, int'(boot_err), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    // A byte offered together with reboot must be dropped.
    byte_data = 8'h55;
    byte_valid = 1'b1;
    do_reboot();
    byte_valid = 1'b0;

    // Single word: 00 00 34 0B 3F.
    lo_a[0] = 'h34;
    hi_a[0] = 'h0B;
    build(1, 0, 1'b0);
    send_all();
    status(1'b1);
    do_reboot();

    // Three words with gaps; the F nibble is summed but not stored.
    gapmax = 3;
    lo_a[0] = 'h11; hi_a[0] = 'h01;
    lo_a[1] = 'h22; hi_a[1] = 'hF2;
    lo_a[2] = 'h33; hi_a[2] = 'h03;
    build(3, 0, 1'b0);
    send_all();
    status(1'b1);
    do_reboot();

    // Same stream, checksum off by one.
    build(3, 0, 1'b1);
    send_all();
    status(1'b0);
    repeat (5) @(negedge clk);
    chk("err_ready", int'(byte_ready), 0);
    do_reboot();

    // Reboot during the in-flight WRITE of word 1.
    build(3, 0, 1'b0);
    void'(exp_q.pop_back());
    for (int i = 0; i < 6; i++) send(bq[i]);
    do_reboot();
    lo_a[0] = 'hAA;
    hi_a[0] = 'h05;
    build(1, 0, 1'b0);
    send_all();
    status(1'b1);
    do_reboot();

    // Full 2048-word load, data = address, junk in unused header bits.
    gapmax = 0;
    for (int i = 0; i < 2048; i++) begin
      lo_a[i] = i % 256;
      hi_a[i] = i / 256 + 16 * $urandom_range(0, 15);
    end
    build(2048, $urandom_range(0, 31), 1'b0);
    send_all();
    status(1'b1);
    chk("last_addr", int'(pram_wr_addr), 'h7FF);
    do_reboot();

    // Random loads, random good/bad checksum.
    gapmax = 2;
    for (int t = 0; t < 4; t++) begin
      int n;
      bit bad;
      n = $urandom_range(1, 12);
      bad = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        lo_a[i] = $urandom_range(0, 255);
        hi_a[i] = $urandom_range(0, 255);
      end
      build(n, $urandom_range(0, 31), bad);
      send_all();
      status(!bad);
      do_reboot();
    end

    // rst while waiting for a HI byte; outputs clear at once.
    lo_a[0] = 'h12; hi_a[0] = 'h0F;
    lo_a[1] = 'h34; hi_a[1] = 'h0E;
    build(2, 0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) send(bq[i]);
    rst = 1'b1;
    #1;
    chk_reset("arst");
    @(negedge clk);
    rst = 1'b0;
    build(2, 0, 1'b0);
    send_all();
    status(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
